// File: rtl/sys1_main_pkg.sv
// Shared constants for the System 1 main-CPU glue: I/O addresses, input-port
// select encodings, ROM1 bank bit map and the sound-queue pointer width helper.
package sys1_main_pkg;

    localparam logic [7:0] IO_SND_A = 8'h14;
    localparam logic [7:0] IO_SND_B = 8'h18;
    localparam logic [7:0] IO_VMD_A = 8'h15;
    localparam logic [7:0] IO_VMD_B = 8'h19;

    typedef enum logic [2:0] {
        PSEL_INP0 = 3'b000,
        PSEL_INP1 = 3'b001,
        PSEL_INP2 = 3'b010,
        PSEL_DSW  = 3'b011,
        PSEL_DSW1 = 3'b100
    } psel_e;

    // Entry i names the VIDMD bit that drives ROM1_BANK[i].
    localparam logic [3:0][2:0] BANK_MAP = {3'd4, 3'd5, 3'd6, 3'd2};

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sys1_sndq.sv
// Sound-command FIFO: head entry visible combinationally, sticky overflow flag
// for pushes dropped while full.
module sys1_sndq
    import sys1_main_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       not_empty,
    output logic       ovf
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];
    logic          full, pop_ok, push_ok;

    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == FULL_CNT);
    assign pop_ok    = pop & not_empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign push_ok   = push & (~full | pop_ok);
    assign dout      = not_empty ? mem_q[rd_q] : 8'h00;
    assign ovf       = ovf_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_ok) wr_d = wr_q + PW'(1);
        if (pop_ok)  rd_d = rd_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push & ~push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/sys1_main_ctrl.sv
// System 1 main-CPU glue: clock enable, address decode, read mux, video mode,
// VBLANK interrupt and sound command path (queue only with SEGASYS1_SNDFIFO_EN).
module sys1_main_ctrl
    import sys1_main_pkg::*;
#(
    parameter int CLKDIV    = 16,
    parameter int BANK_BITS = 2,
    parameter int SQ_DEPTH  = 4
) (
    input  logic                 CLK48M,
    input  logic                 RESET,
    input  logic [15:0]          CPU_AD,
    input  logic [7:0]           CPU_DO,
    input  logic                 CPU_MREQ,
    input  logic                 CPU_IORQ,
    input  logic                 CPU_RD,
    input  logic                 CPU_WR,
    input  logic                 CPU_M1,
    input  logic                 VBLK,
    input  logic                 VIDCS,
    input  logic [7:0]           VIDDO,
    input  logic [23:0]          INP,
    input  logic [15:0]          DSW,
    input  logic [7:0]           ROM0_DO,
    input  logic [7:0]           ROM1_DO,
    input  logic [7:0]           RAM_DO,
    output logic                 CPU_CEN,
    output logic                 CPU_INT,
    output logic [7:0]           CPU_DI,
    output logic                 RAM_WE,
    output logic [BANK_BITS-1:0] ROM1_BANK,
    output logic [7:0]           VIDMD,
    output logic                 SND_RQ,
    output logic [7:0]           SND_NO,
    input  logic                 SND_ACK,
    output logic                 SND_OVF
);

    localparam int DW = $clog2(CLKDIV);

    logic [DW-1:0] div_q, div_d;
    logic          cen_q, cen_d;
    logic [7:0]    vidmd_q, vidmd_d;
    logic          snd_lvl_q, vmd_lvl_q;
    logic          vblk_s1_q, vblk_s2_q, vblk_s3_q;
    logic          irq_q, irq_d;

    logic rom0_sel, rom1_sel, ram_sel, io_rd, port_hit;
    logic snd_dec, vmd_dec, snd_lvl, vmd_lvl, snd_ev, vmd_ev;
    logic vblk_rise, irq_ack;
    logic [7:0] port_data;
    psel_e psel;
    logic  unused_ad;

    assign unused_ad = ^CPU_AD[11:8];

    assign rom0_sel = ~CPU_AD[15];
    assign rom1_sel = (CPU_AD[15:14] == 2'b10);
    assign ram_sel  = (CPU_AD[15:12] == 4'hC);
    assign io_rd    = CPU_IORQ & CPU_RD & ~CPU_M1;
    assign port_hit = (CPU_AD[4:2] <= 3'd4);
    assign psel     = psel_e'(CPU_AD[4:2]);

    assign snd_dec = (CPU_AD[7:0] == IO_SND_A) | (CPU_AD[7:0] == IO_SND_B);
    assign vmd_dec = (CPU_AD[7:0] == IO_VMD_A) | (CPU_AD[7:0] == IO_VMD_B);
    assign snd_lvl = snd_dec & CPU_IORQ & CPU_WR;
    assign vmd_lvl = vmd_dec & CPU_IORQ & CPU_WR;
    // Only the leading cycle of a write strobe counts, however long the CPU holds it.
    assign snd_ev  = snd_lvl & ~snd_lvl_q;
    assign vmd_ev  = vmd_lvl & ~vmd_lvl_q;

    assign vblk_rise = vblk_s2_q & ~vblk_s3_q;
    assign irq_ack   = CPU_M1 & CPU_IORQ;

    assign RAM_WE  = ram_sel & CPU_MREQ & CPU_WR;
    assign CPU_CEN = cen_q;
    assign CPU_INT = irq_q;
    assign VIDMD   = vidmd_q;

    always_comb begin
        port_data = 8'hFF;
        case (psel)
            PSEL_INP0: port_data = INP[7:0];
            PSEL_INP1: port_data = INP[15:8];
            PSEL_INP2: port_data = INP[23:16];
            PSEL_DSW:  port_data = CPU_AD[0] ? DSW[15:8] : DSW[7:0];
            PSEL_DSW1: port_data = DSW[15:8];
            default:   port_data = 8'hFF;
        endcase
    end

    always_comb begin
        CPU_DI = 8'hFF;
        if (VIDCS & CPU_MREQ)            CPU_DI = VIDDO;
        else if (io_rd & vmd_dec)        CPU_DI = vidmd_q;
        else if (io_rd & port_hit)       CPU_DI = port_data;
        else if (CPU_MREQ & ram_sel)     CPU_DI = RAM_DO;
        else if (CPU_MREQ & rom0_sel)    CPU_DI = ROM0_DO;
        else if (CPU_MREQ & rom1_sel)    CPU_DI = ROM1_DO;
    end

    always_comb begin
        div_d   = (div_q == DW'(CLKDIV - 1)) ? '0 : div_q + DW'(1);
        // Registered so the pulse coincides with count 0 yet stays low out of reset.
        cen_d   = (div_q == DW'(CLKDIV - 1));
        vidmd_d = vmd_ev ? CPU_DO : vidmd_q;
        irq_d   = irq_q;
        if (irq_ack)   irq_d = 1'b0;
        if (vblk_rise) irq_d = 1'b1;
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            div_q     <= '0;
            cen_q     <= 1'b0;
            vidmd_q   <= 8'h00;
            snd_lvl_q <= 1'b0;
            vmd_lvl_q <= 1'b0;
            vblk_s1_q <= 1'b0;
            vblk_s2_q <= 1'b0;
            vblk_s3_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            cen_q     <= cen_d;
            vidmd_q   <= vidmd_d;
            snd_lvl_q <= snd_lvl;
            vmd_lvl_q <= vmd_lvl;
            vblk_s1_q <= VBLK;
            vblk_s2_q <= vblk_s1_q;
            vblk_s3_q <= vblk_s2_q;
            irq_q     <= irq_d;
        end
    end

    for (genvar gi = 0; gi < BANK_BITS; gi++) begin : g_bank
        assign ROM1_BANK[gi] = vidmd_q[BANK_MAP[gi]];
    end

`ifdef SEGASYS1_SNDFIFO_EN
    sys1_sndq #(
        .DEPTH(SQ_DEPTH)
    ) u_sndq (
        .clk       (CLK48M),
        .rst       (RESET),
        .push      (snd_ev),
        .din       (CPU_DO),
        .pop       (SND_ACK),
        .dout      (SND_NO),
        .not_empty (SND_RQ),
        .ovf       (SND_OVF)
    );
`else
    localparam int unused_sq_depth = SQ_DEPTH;

    logic [7:0] snd_no_q, snd_no_d;
    logic       snd_rq_q;
    logic       unused_ack;

    assign unused_ack = SND_ACK;

    always_comb begin
        snd_no_d = snd_ev ? CPU_DO : snd_no_q;
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            snd_no_q <= 8'h00;
            snd_rq_q <= 1'b0;
        end else begin
            snd_no_q <= snd_no_d;
            snd_rq_q <= snd_ev;
        end
    end

    assign SND_NO  = snd_no_q;
    assign SND_RQ  = snd_rq_q;
    assign SND_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_sys1_main_ctrl.sv
// Directed bench for sys1_main_ctrl: decode table plus hand sequences for the
// divider, video mode, sound path (either build of SEGASYS1_SNDFIFO_EN) and IRQ.
module tb_sys1_main_ctrl;

    logic        CLK48M = 1'b0;
    logic        RESET;
    logic [15:0] CPU_AD;
    logic [7:0]  CPU_DO;
    logic        CPU_MREQ, CPU_IORQ, CPU_RD, CPU_WR, CPU_M1;
    logic        VBLK, VIDCS;
    logic [7:0]  VIDDO;
    logic [23:0] INP;
    logic [15:0] DSW;
    logic [7:0]  ROM0_DO, ROM1_DO, RAM_DO;
    logic        CPU_CEN, CPU_INT;
    logic [7:0]  CPU_DI;
    logic        RAM_WE;
    logic [1:0]  ROM1_BANK;
    logic [7:0]  VIDMD;
    logic        SND_RQ;
    logic [7:0]  SND_NO;
    logic        SND_ACK;
    logic        SND_OVF;

    int checks   = 0;
    int failures = 0;

    always #10 CLK48M = ~CLK48M;

    sys1_main_ctrl #(
        .CLKDIV(16), .BANK_BITS(2), .SQ_DEPTH(4)
    ) dut (
        .CLK48M(CLK48M), .RESET(RESET),
        .CPU_AD(CPU_AD), .CPU_DO(CPU_DO),
        .CPU_MREQ(CPU_MREQ), .CPU_IORQ(CPU_IORQ), .CPU_RD(CPU_RD),
        .CPU_WR(CPU_WR), .CPU_M1(CPU_M1),
        .VBLK(VBLK), .VIDCS(VIDCS), .VIDDO(VIDDO),
        .INP(INP), .DSW(DSW),
        .ROM0_DO(ROM0_DO), .ROM1_DO(ROM1_DO), .RAM_DO(RAM_DO),
        .CPU_CEN(CPU_CEN), .CPU_INT(CPU_INT), .CPU_DI(CPU_DI),
        .RAM_WE(RAM_WE), .ROM1_BANK(ROM1_BANK), .VIDMD(VIDMD),
        .SND_RQ(SND_RQ), .SND_NO(SND_NO), .SND_ACK(SND_ACK), .SND_OVF(SND_OVF)
    );

    typedef struct packed {
        logic [15:0] ad;
        logic        mreq;
        logic        iorq;
        logic        rd;
        logic        wr;
        logic        vidcs;
        logic [7:0]  di;
        logic        we;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        CPU_AD = 16'h0000; CPU_DO = 8'h00;
        CPU_MREQ = 1'b0; CPU_IORQ = 1'b0; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_M1 = 1'b0;
        VIDCS = 1'b0;
    endtask

    // Strobe held two cycles so a repeated event would be visible.
    task automatic io_wr(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK48M);
        CPU_AD = {8'h00, addr}; CPU_DO = data; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
        @(negedge CLK48M);
        @(negedge CLK48M);
        CPU_IORQ = 1'b0; CPU_WR = 1'b0;
        @(negedge CLK48M);
    endtask

    task automatic ack_pulse();
        @(negedge CLK48M);
        SND_ACK = 1'b1;
        @(negedge CLK48M);
        SND_ACK = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge CLK48M);
        RESET = 1'b1;
        @(negedge CLK48M);
        RESET = 1'b0;
        @(negedge CLK48M);
    endtask

    initial begin
        RESET = 1'b1;
        bus_idle();
        VBLK = 1'b0; SND_ACK = 1'b0;
        VIDDO = 8'h40; INP = 24'hC3B2A1; DSW = 16'hE7D6;
        ROM0_DO = 8'h10; ROM1_DO = 8'h20; RAM_DO = 8'h30;

        vecs[0]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[1]  = '{16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[2]  = '{16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0};
        vecs[3]  = '{16'hBFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0};
        vecs[4]  = '{16'hC000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 1'b0};
        vecs[5]  = '{16'hCFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 1'b0};
        vecs[6]  = '{16'hD000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[7]  = '{16'hC000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0};
        vecs[8]  = '{16'hC123, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 1'b1};
        vecs[9]  = '{16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0};
        vecs[10] = '{16'hD000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b0};
        vecs[12] = '{16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b0};
        vecs[13] = '{16'h0008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0};
        vecs[14] = '{16'h000C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD6, 1'b0};
        vecs[15] = '{16'h000D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE7, 1'b0};
        vecs[16] = '{16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE7, 1'b0};
        vecs[17] = '{16'h0012, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE7, 1'b0};
        vecs[18] = '{16'h0019, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0};
        vecs[19] = '{16'h0015, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0};
        vecs[20] = '{16'h0014, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[21] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};

        // Reset state
        repeat (3) @(negedge CLK48M);
        chk("rst_cen", CPU_CEN, 0);
        chk("rst_int", CPU_INT, 0);
        chk("rst_vidmd", VIDMD, 0);
        chk("rst_bank", ROM1_BANK, 0);
        chk("rst_sndrq", SND_RQ, 0);
        chk("rst_sndno", SND_NO, 0);
        chk("rst_ovf", SND_OVF, 0);
        chk("rst_we", RAM_WE, 0);

        // Clock enable: one pulse every 16 cycles, first at cycle 16
        RESET = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge CLK48M);
            #1;
            chk($sformatf("cen_c%0d", k), CPU_CEN, ((k % 16) == 0) ? 1 : 0);
        end

        // Video mode and ROM1 bank bit map
        io_wr(8'h19, 8'h04);
        chk("vidmd_04", VIDMD, 8'h04);
        chk("bank_04", ROM1_BANK, 2'b01);
        io_wr(8'h15, 8'h40);
        chk("bank_40", ROM1_BANK, 2'b10);
        @(negedge CLK48M);
        CPU_AD = 16'h0015; CPU_DO = 8'h44; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
        chk("vidmd_before_edge", VIDMD, 8'h40);
        @(negedge CLK48M);
        chk("vidmd_44", VIDMD, 8'h44);
        chk("bank_44", ROM1_BANK, 2'b11);
        bus_idle();
        @(negedge CLK48M);

        // Decode / read-mux table
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK48M);
            CPU_AD = vecs[i].ad; CPU_MREQ = vecs[i].mreq; CPU_IORQ = vecs[i].iorq;
            CPU_RD = vecs[i].rd; CPU_WR = vecs[i].wr; VIDCS = vecs[i].vidcs;
            #1;
            chk($sformatf("di_v%0d", i), CPU_DI, vecs[i].di);
            chk($sformatf("we_v%0d", i), RAM_WE, vecs[i].we);
        end
        @(negedge CLK48M);
        bus_idle();
        @(negedge CLK48M);
        chk("vidmd_after_table", VIDMD, 8'h44);

`ifdef SEGASYS1_SNDFIFO_EN
        reset_dut();
        ack_pulse();
        chk("q_ack_empty_rq", SND_RQ, 0);
        chk("q_ack_empty_ovf", SND_OVF, 0);
        @(negedge CLK48M);
        CPU_AD = 16'h0014; CPU_DO = 8'h01; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
        chk("q_rq_before_push", SND_RQ, 0);
        @(negedge CLK48M);
        chk("q_rq_after_push", SND_RQ, 1);
        chk("q_head_01", SND_NO, 8'h01);
        bus_idle();
        @(negedge CLK48M);
        for (int v = 2; v <= 5; v++) io_wr(8'h14, 8'(v));
        chk("q_head_full", SND_NO, 8'h01);
        chk("q_ovf", SND_OVF, 1);
        ack_pulse();
        chk("q_pop1", SND_NO, 8'h02);
        ack_pulse();
        chk("q_pop2", SND_NO, 8'h03);
        ack_pulse();
        chk("q_pop3", SND_NO, 8'h04);
        chk("q_rq_last", SND_RQ, 1);
        ack_pulse();
        chk("q_empty_rq", SND_RQ, 0);
        chk("q_ovf_sticky", SND_OVF, 1);

        // Full queue: push and pop together both succeed
        reset_dut();
        io_wr(8'h18, 8'h11);
        io_wr(8'h14, 8'h22);
        io_wr(8'h18, 8'h33);
        io_wr(8'h14, 8'h44);
        @(negedge CLK48M);
        CPU_AD = 16'h0014; CPU_DO = 8'hAA; CPU_IORQ = 1'b1; CPU_WR = 1'b1; SND_ACK = 1'b1;
        @(negedge CLK48M);
        SND_ACK = 1'b0;
        @(negedge CLK48M);
        bus_idle();
        @(negedge CLK48M);
        chk("qf_ovf", SND_OVF, 0);
        chk("qf_head", SND_NO, 8'h22);
        ack_pulse();
        chk("qf_pop1", SND_NO, 8'h33);
        ack_pulse();
        chk("qf_pop2", SND_NO, 8'h44);
        ack_pulse();
        chk("qf_tail", SND_NO, 8'hAA);
        ack_pulse();
        chk("qf_empty", SND_RQ, 0);
`else
        @(negedge CLK48M);
        CPU_AD = 16'h0018; CPU_DO = 8'h5A; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
        chk("s_rq_before", SND_RQ, 0);
        @(negedge CLK48M);
        chk("s_rq_pulse", SND_RQ, 1);
        chk("s_no_5a", SND_NO, 8'h5A);
        @(negedge CLK48M);
        chk("s_rq_drop", SND_RQ, 0);
        @(negedge CLK48M);
        chk("s_rq_held", SND_RQ, 0);
        bus_idle();
        io_wr(8'h14, 8'hC7);
        chk("s_no_c7", SND_NO, 8'hC7);
        ack_pulse();
        chk("s_ack_ignored", SND_NO, 8'hC7);
        chk("s_ovf_zero", SND_OVF, 0);
`endif

        // VBLANK interrupt
        @(negedge CLK48M);
        VBLK = 1'b1;
        @(negedge CLK48M);
        @(negedge CLK48M);
        chk("irq_sync_delay", CPU_INT, 0);
        @(negedge CLK48M);
        chk("irq_set", CPU_INT, 1);
        VBLK = 1'b0;
        repeat (3) @(negedge CLK48M);
        chk("irq_pending", CPU_INT, 1);
        CPU_M1 = 1'b1; CPU_IORQ = 1'b1;
        @(negedge CLK48M);
        CPU_M1 = 1'b0; CPU_IORQ = 1'b0;
        chk("irq_ack", CPU_INT, 0);
        repeat (3) @(negedge CLK48M);
        VBLK = 1'b1;
        @(negedge CLK48M);
        @(negedge CLK48M);
        CPU_M1 = 1'b1; CPU_IORQ = 1'b1;
        @(negedge CLK48M);
        CPU_M1 = 1'b0; CPU_IORQ = 1'b0;
        chk("irq_edge_with_ack", CPU_INT, 1);
        CPU_M1 = 1'b1; CPU_IORQ = 1'b1;
        @(negedge CLK48M);
        CPU_M1 = 1'b0; CPU_IORQ = 1'b0;
        repeat (3) @(negedge CLK48M);
        chk("irq_level_no_retrigger", CPU_INT, 0);

        // Reset in the middle of a write with an interrupt pending
        VBLK = 1'b0;
        repeat (3) @(negedge CLK48M);
        VBLK = 1'b1;
        repeat (3) @(negedge CLK48M);
        chk("mid_irq_before", CPU_INT, 1);
        CPU_AD = 16'h0015; CPU_DO = 8'h99; CPU_IORQ = 1'b1; CPU_WR = 1'b1;
        RESET = 1'b1;
        @(negedge CLK48M);
        chk("mid_int", CPU_INT, 0);
        chk("mid_vidmd", VIDMD, 0);
        chk("mid_sndrq", SND_RQ, 0);
        bus_idle();
        VBLK = 1'b0;
        @(negedge CLK48M);
        RESET = 1'b0;
        repeat (4) @(negedge CLK48M);
        chk("post_int", CPU_INT, 0);
        chk("post_vidmd", VIDMD, 0);
        chk("post_sndrq", SND_RQ, 0);
        chk("post_sndno", SND_NO, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys1_main_ctrl.md
SYS1_MAIN_CTRL -- requirements
Module: sys1_main_ctrl

Interface
REQ-001 SHALL have parameter CLKDIV, 16, CLK48M cycles per CPU clock-enable pulse (legal 2..64).
REQ-002 SHALL have parameter BANK_BITS, 2, width of the $8000-$BFFF ROM bank select (legal 1..4).
REQ-003 SHALL have parameter SQ_DEPTH, 4, sound-command FIFO depth (power of 2, legal 2..16).
REQ-004 SHALL have port CLK48M  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports CPU_AD in 16, CPU_DO in 8, CPU_MREQ/CPU_IORQ/CPU_RD/CPU_WR/CPU_M1 in 1 each: Z80 bus, active-high strobes.
REQ-007 SHALL have port VBLK  in  1  asynchronous vertical-blank level.
REQ-008 SHALL have ports VIDCS in 1, VIDDO in 8: video-space select and read data.
REQ-009 SHALL have ports INP in 24 (three input ports), DSW in 16 (two DIP banks).
REQ-010 SHALL have ports ROM0_DO, ROM1_DO, RAM_DO  in  8 each: memory read data.
REQ-011 SHALL have ports CPU_CEN out 1, CPU_INT out 1, CPU_DI out 8.
REQ-012 SHALL have ports RAM_WE out 1, ROM1_BANK out BANK_BITS, VIDMD out 8.
REQ-013 SHALL have ports SND_RQ out 1, SND_NO out 8, SND_ACK in 1, SND_OVF out 1.

Function
REQ-014 SHALL count 0..CLKDIV-1 free-running; CPU_CEN high for exactly one CLK48M cycle when count is 0.
REQ-015 SHALL decode: ROM0 $0000-$7FFF, ROM1 $8000-$BFFF, RAM $C000-$CFFF (MREQ); I/O on CPU_AD[7:0]: sound $14/$18, video mode $15/$19; ports per CPU_AD[4:2]: 000 INP[7:0], 001 INP[15:8], 010 INP[23:16], 011 with A0=0 DSW[7:0], 011 with A0=1 or 100 DSW[15:8].
REQ-016 SHALL drive CPU_DI combinationally, priority: VIDCS&MREQ->VIDDO, video mode->VIDMD, port->input, RAM, ROM0, ROM1, else $FF.
REQ-017 SHALL assert RAM_WE = RAM decode & CPU_MREQ & CPU_WR, combinational.
REQ-018 SHALL qualify I/O writes on the rising edge of (decode & CPU_IORQ & CPU_WR) using a registered previous value: exactly one write event per bus cycle, held strobe never repeats.
REQ-019 SHALL load VIDMD from CPU_DO on a video-mode write event, visible the next cycle.
REQ-020 SHALL form ROM1_BANK bit i from VIDMD bit map {2,6,5,4}[i], so the default yields {VIDMD[6],VIDMD[2]}.
REQ-021 SHALL synchronise VBLK with two flops; synchronised rising edge sets irq pending; CPU_INT = pending.
REQ-022 SHALL clear pending on CPU_M1 & CPU_IORQ (acknowledge); simultaneous edge and acknowledge leaves pending set.
REQ-023 SHALL push CPU_DO into the sound FIFO on a sound write event; SND_RQ = not empty, SND_NO = head entry, SND_RQ rises the cycle after the push into an empty FIFO.
REQ-024 SHALL pop on a one-cycle SND_ACK pulse when not empty; SND_ACK while empty is ignored.
REQ-025 SHALL drop a push when full and not popping, and set SND_OVF sticky; push and pop in the same cycle when full both succeed without overflow; pointers wrap modulo SQ_DEPTH.

Reset
REQ-026 SHALL on RESET clear divider, VIDMD, ROM1_BANK, FIFO pointers/count, SND_NO, SND_RQ, SND_OVF, irq pending, edge and sync flops, all to 0, asynchronously.
REQ-027 SHALL abandon any in-progress write or pending interrupt on reset mid-operation; no event fires on the first cycle after release unless a new edge occurs.

Configuration
REQ-028 SHALL compile the FIFO only with SEGASYS1_SNDFIFO_EN defined; without it, SND_NO latches every sound write, SND_RQ is a one-cycle pulse the cycle after, SND_ACK is ignored, SND_OVF is tied 0 and SQ_DEPTH is unused.

Structure
REQ-029 SHALL place I/O address constants, the port-select encodings, the bank bit-map table and the FIFO pointer width function in package sys1_main_pkg.
REQ-030 SHALL implement the FIFO as sub-module sys1_sndq (parameter DEPTH), instantiated only under the macro.

Verification
REQ-031 SHALL check reset release with CLKDIV=16 -> CPU_CEN at cycles 16,32,48; all outputs 0.
REQ-032 SHALL check write $44 to I/O $15 -> VIDMD=$44, ROM1_BANK=2'b11; read I/O $19 -> CPU_DI=$44.
REQ-033 SHALL check writes $01..$05 to $14 (FIFO, depth 4), no ack -> SND_NO=$01, SND_OVF=1; four acks -> $02,$03,$04 then SND_RQ=0.
REQ-034 SHALL check full FIFO, push $AA with simultaneous SND_ACK -> no overflow, tail entry $AA.
REQ-035 SHALL check VBLK rise -> CPU_INT within 3 cycles; M1&IORQ -> CPU_INT=0; edge coincident with ack -> CPU_INT stays 1.
REQ-036 SHALL check read I/O $0D -> DSW[15:8], $10 -> DSW[15:8], unmapped $D000 MREQ -> $FF.
